// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// MMIO register offsets, default window base and region select.
package dmem_pkg;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hBFAF;

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_TIMER   = 16'h0004;
  localparam logic [15:0] OFF_COMPARE = 16'h0008;
  localparam logic [15:0] OFF_STATUS  = 16'h000C;

  typedef enum logic {
    REGION_RAM,
    REGION_MMIO
  } region_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port bus between the core and the memory responder.
// master = core side, slave = responder side.
interface dmem_responder_if;

  logic [31:0] mem_addr;
  logic [31:0] Write_data;
  logic        mem_en;
  logic        mem_write_en;
  logic [31:0] Read_data;

  modport master (
    output mem_addr,
    output Write_data,
    output mem_en,
    output mem_write_en,
    input  Read_data
  );

  modport slave (
    input  mem_addr,
    input  Write_data,
    input  mem_en,
    input  mem_write_en,
    output Read_data
  );

endinterface

// File: rtl/dmem_timer.sv
// Free-running timer with compare register and sticky match flag.
// Core loads win over increment; a match set wins over a clear.
module dmem_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_we,
  input  logic        cmp_we,
  input  logic        clr,
  input  logic [31:0] wdata,
  output logic [31:0] timer,
  output logic [31:0] compare,
  output logic        match
);

  logic hit;

  assign hit = (compare != '0) && (timer == compare);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      compare <= '0;
      match   <= 1'b0;
    end else begin
      timer <= timer_we ? wdata : timer + 32'd1;
      if (cmp_we)
        compare <= wdata;
      if (hit)
        match <= 1'b1;
      else if (clr)
        match <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM plus MMIO LED/timer/compare/status.
// Define ALIGN_CHECK_EN to suppress misaligned accesses and flag them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter int          LED_W     = 16,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  output logic [LED_W-1:0] led,
  output logic             timer_irq,
  output logic             align_err
);

  logic [31:0]     ram [2**RAM_AW];
  logic [RAM_AW-1:0] idx;
  logic [15:0]     off;
  region_e         region;
  logic            misalign;
  logic            acc_ok;
  logic            wr;
  logic            rd;
  logic            mmio_wr;
  logic [31:0]     timer;
  logic [31:0]     compare;
  logic            match;

  assign idx    = bus.mem_addr[RAM_AW+1:2];
  assign off    = bus.mem_addr[15:0];
  assign region = (bus.mem_addr[31:16] == MMIO_BASE)
                ? REGION_MMIO : REGION_RAM;

`ifdef ALIGN_CHECK_EN
  assign misalign = bus.mem_addr[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (rst)
      align_err <= 1'b0;
    else if (bus.mem_en && misalign)
      align_err <= 1'b1;
  end
`else
  logic unused_lsb;
  assign unused_lsb = ^bus.mem_addr[1:0];
  assign misalign   = 1'b0;
  assign align_err  = 1'b0;
`endif

  assign acc_ok  = bus.mem_en && !misalign;
  assign wr      = acc_ok && bus.mem_write_en;
  assign rd      = acc_ok && !bus.mem_write_en;
  assign mmio_wr = wr && (region == REGION_MMIO);

  // RAM is never reset; a write during reset is dropped
  always_ff @(posedge clk) begin
    if (!rst && wr && region == REGION_RAM)
      ram[idx] <= bus.Write_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      led <= '0;
    else if (mmio_wr && off == OFF_LED)
      led <= bus.Write_data[LED_W-1:0];
  end

  dmem_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .timer_we (mmio_wr && off == OFF_TIMER),
    .cmp_we   (mmio_wr && off == OFF_COMPARE),
    .clr      (mmio_wr && off == OFF_STATUS
               && bus.Write_data[0]),
    .wdata    (bus.Write_data),
    .timer    (timer),
    .compare  (compare),
    .match    (match)
  );

  assign timer_irq = match;

  always_comb begin
    bus.Read_data = '0;
    if (rd) begin
      unique case (region)
        REGION_RAM:  bus.Read_data = ram[idx];
        REGION_MMIO: begin
          unique case (off)
            OFF_LED:     bus.Read_data = 32'(led);
            OFF_TIMER:   bus.Read_data = timer;
            OFF_COMPARE: bus.Read_data = compare;
            OFF_STATUS:  bus.Read_data = {31'b0, match};
            default:     bus.Read_data = '0;
          endcase
        end
        default: bus.Read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder.
// Build with +define+ALIGN_CHECK_EN to exercise the alignment check.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] led;
  logic        timer_irq;
  logic        align_err;
  int          n_checks;
  int          n_errors;
  logic [31:0] rv;

  localparam logic [31:0] A_LED   = 32'hBFAF0000;
  localparam logic [31:0] A_TIMER = 32'hBFAF0004;
  localparam logic [31:0] A_CMP   = 32'hBFAF0008;
  localparam logic [31:0] A_STAT  = 32'hBFAF000C;
  localparam logic [31:0] A_HOLE  = 32'hBFAF0020;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .led       (led),
    .timer_irq (timer_irq),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_en       = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_addr     = '0;
    bus.Write_data   = '0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    bus.mem_addr     = a;
    bus.Write_data   = d;
    bus.mem_en       = 1'b1;
    bus.mem_write_en = 1'b1;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    bus.mem_addr     = a;
    bus.mem_en       = 1'b1;
    bus.mem_write_en = 1'b0;
    #1;
    d = bus.Read_data;
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_irq", 32'(timer_irq), 32'h0);
    chk("rst_align", 32'(align_err), 32'h0);
    rst = 1'b0;
    rd(A_TIMER, rv);
    chk("timer_t0", rv, 32'd0);
    step();
    rd(A_TIMER, rv);
    chk("timer_t1", rv, 32'd1);
    step();
    rd(A_TIMER, rv);
    chk("timer_t2", rv, 32'd2);

    wr(32'h14, 32'h11111111);
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10, rv);
    chk("ram_rd", rv, 32'hDEADBEEF);
    rd(32'h14, rv);
    chk("ram_nbr", rv, 32'h11111111);
    rd(32'h1010, rv);
    chk("ram_alias", rv, 32'hDEADBEEF);
    bus.mem_addr = 32'h10;
    #1;
    chk("rd_en0", bus.Read_data, 32'h0);
    bus.mem_en       = 1'b1;
    bus.mem_write_en = 1'b1;
    bus.Write_data   = 32'hDEADBEEF;
    #1;
    chk("rd_during_wr", bus.Read_data, 32'h0);
    idle();

    wr(A_LED, 32'h1234ABCD);
    chk("led_out", 32'(led), 32'h0000ABCD);
    rd(A_LED, rv);
    chk("led_rd", rv, 32'h0000ABCD);
    rd(A_HOLE, rv);
    chk("hole_rd", rv, 32'h0);
    wr(A_HOLE, 32'hFFFFFFFF);
    rd(A_HOLE, rv);
    chk("hole_rd2", rv, 32'h0);
    chk("hole_led", 32'(led), 32'h0000ABCD);

    wr(A_CMP, 32'd20);
    wr(A_TIMER, 32'd10);
    for (int i = 0; i < 10; i++) step();
    chk("irq_pre", 32'(timer_irq), 32'h0);
    step();
    chk("irq_set", 32'(timer_irq), 32'h1);
    rd(A_STAT, rv);
    chk("stat_rd", rv, 32'h1);
    wr(A_STAT, 32'h1);
    chk("irq_clr", 32'(timer_irq), 32'h0);
    wr(A_TIMER, 32'd100);
    wr(A_CMP, 32'd101);
    wr(A_STAT, 32'h1);
    chk("set_wins", 32'(timer_irq), 32'h1);
    wr(A_STAT, 32'h1);
    chk("irq_clr2", 32'(timer_irq), 32'h0);
    wr(A_CMP, 32'd0);
    wr(A_TIMER, 32'd0);
    step();
    step();
    chk("cmp0_off", 32'(timer_irq), 32'h0);

    wr(A_TIMER, 32'hFFFFFFFE);
    rd(A_TIMER, rv);
    chk("wrap_a", rv, 32'hFFFFFFFE);
    step();
    rd(A_TIMER, rv);
    chk("wrap_b", rv, 32'hFFFFFFFF);
    step();
    rd(A_TIMER, rv);
    chk("wrap_c", rv, 32'h0);
    step();
    wr(A_TIMER, 32'h00001234);
    rd(A_TIMER, rv);
    chk("load", rv, 32'h00001234);

    wr(32'h12, 32'h55);
`ifdef ALIGN_CHECK_EN
    rd(32'h10, rv);
    chk("al_ram", rv, 32'hDEADBEEF);
    chk("al_err", 32'(align_err), 32'h1);
    rd(32'h12, rv);
    chk("al_rd0", rv, 32'h0);
    step();
    chk("al_sticky", 32'(align_err), 32'h1);
`else
    rd(32'h10, rv);
    chk("al_ram", rv, 32'h55);
    chk("al_err", 32'(align_err), 32'h0);
`endif

    rst              = 1'b1;
    bus.mem_addr     = A_LED;
    bus.Write_data   = 32'h00005555;
    bus.mem_en       = 1'b1;
    bus.mem_write_en = 1'b1;
    step();
    idle();
    rst = 1'b0;
    chk("mrst_led", 32'(led), 32'h0);
    chk("mrst_align", 32'(align_err), 32'h0);
    rd(A_TIMER, rv);
    chk("mrst_timer", rv, 32'h0);
    rd(A_CMP, rv);
    chk("mrst_cmp", rv, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
